// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register and its burst controller.
package usr_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    function automatic logic is_shift_mode(input mode_t mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL);
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst-shift sequencer: owns the remaining count, latched direction/rotate, busy and done,
// and tells the datapath when and which way to shift on each edge.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  mode_t            mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             rot_in,
    output logic             shift_en_c,
    output logic             shift_left_c,
    output logic             rot_c,
    output logic             busy,
    output logic             done
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             left_q, left_d;
    logic             rot_q, rot_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            left_q      <= 1'b0;
            rot_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            left_q      <= left_d;
            rot_q       <= rot_d;
            done_q      <= done_d;
        end
    end

    // The first shift of a burst happens on the start edge itself, so a 1-shift burst never goes busy.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        left_d       = left_q;
        rot_d        = rot_q;
        done_d       = 1'b0;
        shift_en_c   = 1'b0;
        shift_left_c = left_q;
        rot_c        = rot_q;
        case (state_q)
            ST_IDLE: begin
                shift_left_c = (mode == MODE_SHL);
                rot_c        = rot_in;
                if (is_shift_mode(mode)) begin
                    if (start) begin
                        left_d = (mode == MODE_SHL);
                        rot_d  = rot_in;
                        if (count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            shift_en_c  = 1'b1;
                            remaining_d = count - CNT_W'(1);
                            if (count == CNT_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_BUSY;
                            end
                        end
                    end else begin
                        shift_en_c = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                shift_en_c  = 1'b1;
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign done = done_q;

endmodule

// File: rtl/universal_shift_register_n.sv
// WIDTH-bit universal shift register with burst-shift engine and serial chaining outputs.
// Optional rotate mode is enabled by defining USR_ROTATE_EN (adds the rot input).
module universal_shift_register_n
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             s1,
    input  logic             s0,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic [WIDTH-1:0] i_par,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] a_par,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    mode_t            mode;
    logic             rot_sel;
    logic             shift_en_c;
    logic             shift_left_c;
    logic             rot_c;
    logic [WIDTH-1:0] par_d;

    assign mode = mode_t'({s1, s0});

`ifdef USR_ROTATE_EN
    assign rot_sel = rot;
`else
    assign rot_sel = 1'b0;
`endif

    usr_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk          (clk),
        .clear        (clear),
        .mode         (mode),
        .start        (start),
        .count        (count),
        .rot_in       (rot_sel),
        .shift_en_c   (shift_en_c),
        .shift_left_c (shift_left_c),
        .rot_c        (rot_c),
        .busy         (busy),
        .done         (done)
    );

    // Rotation feeds the outgoing bit back in at the opposite end instead of the serial input.
    always_comb begin
        par_d = a_par;
        if (shift_en_c) begin
            if (shift_left_c) begin
                par_d = {a_par[WIDTH-2:0], (rot_c ? a_par[WIDTH-1] : lsb_in)};
            end else begin
                par_d = {(rot_c ? a_par[0] : msb_in), a_par[WIDTH-1:1]};
            end
        end else if (!busy && (mode == MODE_LOAD)) begin
            par_d = i_par;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            a_par <= '0;
        end else begin
            a_par <= par_d;
        end
    end

    assign msb_out = a_par[WIDTH-1];
    assign lsb_out = a_par[0];

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Directed self-checking bench for universal_shift_register_n with an expected-value queue.
// Rotate checks are included when USR_ROTATE_EN is defined.
module tb_universal_shift_register_n;

    logic       clk;
    logic       clear;
    logic       s1, s0;
    logic       msb_in, lsb_in;
    logic [7:0] i_par;
    logic       start;
    logic [3:0] count;
    logic       rot;
    logic [7:0] a_par;
    logic       msb_out, lsb_out;
    logic       busy, done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sb_q[$];

    universal_shift_register_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .clear   (clear),
        .s1      (s1),
        .s0      (s0),
        .msb_in  (msb_in),
        .lsb_in  (lsb_in),
        .i_par   (i_par),
        .start   (start),
        .count   (count),
`ifdef USR_ROTATE_EN
        .rot     (rot),
`endif
        .a_par   (a_par),
        .msb_out (msb_out),
        .lsb_out (lsb_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic expect_push(input string tag, input logic [7:0] a, input logic b, input logic d);
        exp_t e;
        e.tag = tag;
        e.a   = a;
        e.b   = b;
        e.d   = d;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb_q.pop_front();
        tests_run++;
        assert (a_par === e.a) else begin
            tests_failed++;
            $error("FAIL %s a_par: got %h expected %h", e.tag, a_par, e.a);
        end
        tests_run++;
        assert (busy === e.b) else begin
            tests_failed++;
            $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.b);
        end
        tests_run++;
        assert (done === e.d) else begin
            tests_failed++;
            $error("FAIL %s done: got %b expected %b", e.tag, done, e.d);
        end
        tests_run++;
        assert ({msb_out, lsb_out} === {e.a[7], e.a[0]}) else begin
            tests_failed++;
            $error("FAIL %s serial_out: got %b%b expected %b%b", e.tag, msb_out, lsb_out, e.a[7], e.a[0]);
        end
    endtask

    // Drive is already applied; expect the result one edge later.
    task automatic step(input string tag, input logic [7:0] a, input logic b, input logic d);
        expect_push(tag, a, b, d);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic drive(input logic [1:0] m, input logic st, input logic [3:0] n);
        {s1, s0} = m;
        start    = st;
        count    = n;
    endtask

    initial begin
        clk = 1'b0; clear = 1'b0; s1 = 1'b0; s0 = 1'b0;
        msb_in = 1'b0; lsb_in = 1'b0; i_par = 8'h00;
        start = 1'b0; count = 4'd0; rot = 1'b0;

        #3;
        expect_push("reset", 8'h00, 1'b0, 1'b0);
        check_pop();
        @(posedge clk); #1;
        clear = 1'b1;

        i_par = 8'hA5; drive(2'b11, 1'b0, 4'd0);
        step("load_a5", 8'hA5, 1'b0, 1'b0);
        msb_in = 1'b1; drive(2'b01, 1'b0, 4'd0);
        step("idle_shr", 8'hD2, 1'b0, 1'b0);
        lsb_in = 1'b0; drive(2'b10, 1'b0, 4'd0);
        step("idle_shl", 8'hA4, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 4'd0);
        step("hold", 8'hA4, 1'b0, 1'b0);

        // Burst right by 3
        i_par = 8'h80; drive(2'b11, 1'b0, 4'd0);
        step("load_80", 8'h80, 1'b0, 1'b0);
        msb_in = 1'b0; drive(2'b01, 1'b1, 4'd3);
        step("bshr_e0", 8'h40, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 4'd0);
        step("bshr_e1", 8'h20, 1'b1, 1'b0);
        step("bshr_e2", 8'h10, 1'b0, 1'b1);
        step("bshr_after", 8'h10, 1'b0, 1'b0);

        // count = 0
        drive(2'b01, 1'b1, 4'd0);
        step("cnt0", 8'h10, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 4'd0);
        step("cnt0_after", 8'h10, 1'b0, 1'b0);

        // count = 1
        lsb_in = 1'b1; drive(2'b10, 1'b1, 4'd1);
        step("cnt1", 8'h21, 1'b0, 1'b1);
        drive(2'b00, 1'b0, 4'd0);
        step("cnt1_after", 8'h21, 1'b0, 1'b0);

        // start with load mode is ignored
        i_par = 8'h5A; drive(2'b11, 1'b1, 4'd3);
        step("load_start", 8'h5A, 1'b0, 1'b0);

        // Long left burst, controls toggled while busy, then clear after shift 5
        lsb_in = 1'b1; drive(2'b10, 1'b1, 4'd10);
        step("long_s1", 8'hB5, 1'b1, 1'b0);
        i_par = 8'hFF; drive(2'b11, 1'b1, 4'd2);
        step("long_s2", 8'h6B, 1'b1, 1'b0);
        drive(2'b01, 1'b0, 4'd1);
        step("long_s3", 8'hD7, 1'b1, 1'b0);
        lsb_in = 1'b0; drive(2'b00, 1'b1, 4'd0);
        step("long_s4", 8'hAE, 1'b1, 1'b0);
        lsb_in = 1'b1; drive(2'b11, 1'b0, 4'd5);
        step("long_s5", 8'h5D, 1'b1, 1'b0);
        clear = 1'b0;
        #1;
        expect_push("async_clear", 8'h00, 1'b0, 1'b0);
        check_pop();
        step("clear_held", 8'h00, 1'b0, 1'b0);
        clear = 1'b1; drive(2'b00, 1'b0, 4'd0);
        step("clear_no_done", 8'h00, 1'b0, 1'b0);

        // Back-to-back burst started on the done cycle
        i_par = 8'h01; drive(2'b11, 1'b0, 4'd0);
        step("load_01", 8'h01, 1'b0, 1'b0);
        lsb_in = 1'b0; drive(2'b10, 1'b1, 4'd1);
        step("b2b_first", 8'h02, 1'b0, 1'b1);
        drive(2'b10, 1'b1, 4'd2);
        step("b2b_second_e0", 8'h04, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 4'd0);
        step("b2b_second_e1", 8'h08, 1'b0, 1'b1);
        step("b2b_after", 8'h08, 1'b0, 1'b0);

        // Burst longer than the width: serial bits fully replace contents
        msb_in = 1'b1; drive(2'b01, 1'b1, 4'd9);
        step("wide_e0", 8'h84, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 4'd0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
        end
        #1;
        expect_push("wide_e7", 8'hFF, 1'b1, 1'b0);
        check_pop();
        step("wide_e8", 8'hFF, 1'b0, 1'b1);

`ifdef USR_ROTATE_EN
        i_par = 8'h81; drive(2'b11, 1'b0, 4'd0);
        step("rot_load", 8'h81, 1'b0, 1'b0);
        rot = 1'b1; msb_in = 1'b0; drive(2'b01, 1'b1, 4'd1);
        step("rot_burst_r", 8'hC0, 1'b0, 1'b1);
        lsb_in = 1'b0; drive(2'b10, 1'b1, 4'd2);
        step("rot_b2b_e0", 8'h81, 1'b1, 1'b0);
        rot = 1'b0; drive(2'b00, 1'b0, 4'd0);
        step("rot_latched", 8'h03, 1'b0, 1'b1);
        rot = 1'b1; drive(2'b01, 1'b0, 4'd0);
        step("rot_idle_r", 8'h81, 1'b0, 1'b0);
        rot = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
